// File: rtl/forex_pkg.sv
// -----------------------------------------------------------------------------
// forex_pkg
// Shared types and constants for the arbitrage host path (FOREX top, Container
// core, edge_update_sequencer).
//   - PRED_W_DEF / WEIGHT_W_DEF : default vertex-index and weight widths
//                                 (same values as the Const.vh widths).
//   - ADDR_*                    : Avalon register map of the update sequencer.
//   - seq_state_t               : sequencer FSM states.
//   - edge_update_t             : one edge update {src, dst, e} at default widths.
//   - count_width()             : width of a 0..DEPTH occupancy counter.
// -----------------------------------------------------------------------------
package forex_pkg;

    localparam int PRED_W_DEF   = 6;
    localparam int WEIGHT_W_DEF = 32;

    localparam logic [2:0] ADDR_STAGE_VTX = 3'd0;  // write: {src, dst}
    localparam logic [2:0] ADDR_STAGE_E   = 3'd1;  // write: weight
    localparam logic [2:0] ADDR_COMMIT    = 3'd2;  // write: push staged triple
    localparam logic [2:0] ADDR_CLR_OVF   = 3'd3;  // write: clear sticky overflow
    localparam logic [2:0] ADDR_STATUS    = 3'd0;  // read : status word

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [PRED_W_DEF-1:0]   src;
        logic [PRED_W_DEF-1:0]   dst;
        logic [WEIGHT_W_DEF-1:0] e;
    } edge_update_t;

    // Occupancy counter must represent DEPTH itself, hence one extra bit.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/update_fifo.sv
// -----------------------------------------------------------------------------
// update_fifo
// Synchronous FIFO of edge-update records with an extra tail-write port so the
// most recently pushed entry can be rewritten in place (update coalescing).
// Ports:
//   clk, reset        : clock, synchronous active-high reset (empties FIFO)
//   push, push_data   : append a record (caller guarantees !full || pop)
//   pop               : drop the head record (caller guarantees !empty)
//   tail_wr, tail_data: overwrite the tail record (never together with push)
//   head, tail        : current head / tail record
//   count             : occupancy 0..DEPTH
//   full, empty       : occupancy flags
// -----------------------------------------------------------------------------
module update_fifo
    import forex_pkg::*;
#(
    parameter int DATA_W = 44,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = count_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              tail_wr,
    input  logic [DATA_W-1:0] tail_data,
    output logic [DATA_W-1:0] head,
    output logic [DATA_W-1:0] tail,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     tail_ptr;

    // DEPTH is a power of two, so pointer arithmetic wraps on its own.
    assign tail_ptr = wr_ptr - AW'(1);
    assign head     = mem[rd_ptr];
    assign tail     = mem[tail_ptr];
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);

    // Storage is not reset; occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
        else if (tail_wr)
            mem[tail_ptr] <= tail_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/edge_update_sequencer.sv
// -----------------------------------------------------------------------------
// edge_update_sequencer
// Avalon-slave front end that stages host edge updates {src, dst, e} into a
// FIFO and feeds them to the Container core one at a time, one start/done
// handshake per update, so host writes never disturb a running pass.
//
// Register map (write when chipselect && write):
//   0 W : stage_src <= wd[2*PRED_W-1:PRED_W], stage_dst <= wd[PRED_W-1:0]
//   1 W : stage_e   <= wd
//   2 W : commit staged triple (staging registers kept for recommit)
//   3 W : clear sticky overflow
//   0 R : {overflow, busy, 0.., count}, readdata valid the cycle after read
//   other addresses: writes ignored, reads return 0
//
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   chipselect, write, read      : Avalon strobes
//   address, writedata, readdata : Avalon address / data (readdata registered)
//   c_start                      : one-cycle start pulse to the container
//   c_src, c_dst, c_e            : update presented to the container, held
//                                  until the next start
//   c_done                       : container completion pulse (WAIT only)
//   busy                         : FSM not idle or FIFO non-empty
//
// Build option: define UPDATE_COALESCE_EN to let a commit whose {src, dst}
// matches the FIFO tail overwrite that entry's weight instead of pushing.
// -----------------------------------------------------------------------------
module edge_update_sequencer
    import forex_pkg::*;
#(
    parameter int PRED_W   = PRED_W_DEF,
    parameter int WEIGHT_W = WEIGHT_W_DEF,
    parameter int DEPTH    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                chipselect,
    input  logic                write,
    input  logic                read,
    input  logic [2:0]          address,
    input  logic [WEIGHT_W-1:0] writedata,
    output logic [WEIGHT_W-1:0] readdata,
    output logic                c_start,
    output logic [PRED_W-1:0]   c_src,
    output logic [PRED_W-1:0]   c_dst,
    output logic [WEIGHT_W-1:0] c_e,
    input  logic                c_done,
    output logic                busy
);

    localparam int REC_W = 2 * PRED_W + WEIGHT_W;
    localparam int CNT_W = count_width(DEPTH);

`ifdef UPDATE_COALESCE_EN
    localparam bit COAL_EN = 1'b1;
`else
    localparam bit COAL_EN = 1'b0;
`endif

    seq_state_t          state;
    logic [PRED_W-1:0]   stage_src;
    logic [PRED_W-1:0]   stage_dst;
    logic [WEIGHT_W-1:0] stage_e;
    logic                overflow;

    logic                wr_en;
    logic                rd_en;
    logic                commit;
    logic                clr_ovf;
    logic                pop;
    logic                push;
    logic                coal_hit;
    logic                ovf_set;
    logic [REC_W-1:0]    stage_rec;
    logic [REC_W-1:0]    fifo_head;
    logic [REC_W-1:0]    fifo_tail;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic [WEIGHT_W-1:0] status;

    assign wr_en     = chipselect && write;
    assign rd_en     = chipselect && read;
    assign commit    = wr_en && (address == ADDR_COMMIT);
    assign clr_ovf   = wr_en && (address == ADDR_CLR_OVF);
    assign stage_rec = {stage_src, stage_dst, stage_e};

    // The head leaves the FIFO during the single ISSUE cycle.
    assign pop = (state == ST_ISSUE);

    // Coalescing must not touch an entry that is being popped this cycle,
    // which is only possible when the tail is also the head (count == 1).
    assign coal_hit = COAL_EN && commit
                   && ((fifo_count > CNT_W'(1)) || ((fifo_count == CNT_W'(1)) && !pop))
                   && (fifo_tail[REC_W-1 -: 2*PRED_W] == {stage_src, stage_dst});

    // A full FIFO still accepts a commit when the head is popped that cycle.
    assign push    = commit && !coal_hit && (!fifo_full || pop);
    assign ovf_set = commit && !coal_hit && fifo_full && !pop;

    update_fifo #(
        .DATA_W (REC_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (stage_rec),
        .pop       (pop),
        .tail_wr   (coal_hit),
        .tail_data (stage_rec),
        .head      (fifo_head),
        .tail      (fifo_tail),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign busy = (state != ST_IDLE) || !fifo_empty;

    // ---------------------------------------------------------------- staging
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_src <= '0;
            stage_dst <= '0;
            stage_e   <= '0;
            overflow  <= 1'b0;
        end else begin
            if (wr_en && (address == ADDR_STAGE_VTX)) begin
                stage_src <= writedata[2*PRED_W-1:PRED_W];
                stage_dst <= writedata[PRED_W-1:0];
            end
            if (wr_en && (address == ADDR_STAGE_E))
                stage_e <= writedata;
            // Set takes priority over a clear in the same cycle.
            if (ovf_set)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    // ---------------------------------------------------------------- status
    always_comb begin
        status                = '0;
        status[WEIGHT_W-1]    = overflow;
        status[WEIGHT_W-2]    = busy;
        status[CNT_W-1:0]     = fifo_count;
    end

    always_ff @(posedge clk) begin
        if (reset)
            readdata <= '0;
        else if (rd_en)
            readdata <= (address == ADDR_STATUS) ? status : '0;
    end

    // ---------------------------------------------------------------- FSM
    // Outputs are registered on the IDLE->ISSUE transition so they are valid
    // for the whole ISSUE cycle in which c_start is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            c_start <= 1'b0;
            c_src   <= '0;
            c_dst   <= '0;
            c_e     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state   <= ST_ISSUE;
                        c_start <= 1'b1;
                        c_src   <= fifo_head[REC_W-1 -: PRED_W];
                        c_dst   <= fifo_head[WEIGHT_W+PRED_W-1 -: PRED_W];
                        // A same-cycle coalesce into the single entry rewrites
                        // the head at this edge; forward the new weight.
                        c_e     <= (coal_hit && (fifo_count == CNT_W'(1)))
                                   ? stage_e : fifo_head[WEIGHT_W-1:0];
                    end
                end
                ST_ISSUE: begin
                    c_start <= 1'b0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (c_done)
                        state <= ST_IDLE;
                end
                default: begin
                    c_start <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
